// File: rtl/vo_frame_seq.sv
// vo_frame_seq: frame-streaming sequencer for the visual-odometry datapath.
// Runs n_of_f feature frames on port 0, then n_of_d direct iterations in which
// port 1 streams the current frame and port 0 trails it by P_REF_LAG cycles.
// Optional build macro: VO_SEQ_TIMEOUT_EN adds a wait-state watchdog (o_err).
module vo_frame_seq #(
  parameter int P_REF_LAG = 19840,
  parameter int P_POSE_BW = 42,
  parameter int P_TIMEOUT = 2000000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_seq_start,
  input  logic [3:0]               i_n_of_f,
  input  logic [3:0]               i_n_of_d,
  input  logic [9:0]               i_hsize,
  input  logic [9:0]               i_vsize,
  input  logic [12*P_POSE_BW-1:0]  i_init_pose,
  input  logic [83:0]              i_sigma_icp,
  input  logic [8:0]               i_sigma_rgbd,
  input  logic                     i_feature_ready,
  input  logic                     i_done,
  input  logic                     i_update_done,
  input  logic [12*P_POSE_BW-1:0]  i_new_pose,
  input  logic [83:0]              i_sigma_icp_next,
  input  logic [8:0]               i_sigma_rgbd_next,
  output logic                     o_frame_start,
  output logic                     o_f_or_d,
  output logic                     o_valid_0,
  output logic                     o_valid_1,
  output logic [18:0]              o_idx_0,
  output logic [18:0]              o_idx_1,
  output logic [3:0]               o_frame_sel,
  output logic [12*P_POSE_BW-1:0]  o_pose,
  output logic [83:0]              o_sigma_icp,
  output logic [8:0]               o_sigma_rgbd,
  output logic                     o_busy,
  output logic                     o_seq_done,
  output logic                     o_err
);

  localparam int PW = 12 * P_POSE_BW;
  // Stream cycle counter must cover P_REF_LAG plus a full 20-bit frame.
  localparam int CW = 22;
  localparam logic [CW-1:0] LAG_C = CW'(P_REF_LAG);

  typedef enum logic [2:0] {
    S_IDLE, S_F_STREAM, S_F_WAIT, S_D_STREAM, S_D_WAIT, S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      n_of_f_q, n_of_f_d;
  logic [3:0]      n_of_d_q, n_of_d_d;
  logic [19:0]     n_q, n_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [3:0]      iter_q, iter_d;
  logic [3:0]      frame_sel_q, frame_sel_d;
  logic            f_or_d_q, f_or_d_d;
  logic [PW-1:0]   pose_q, pose_d;
  logic [83:0]     sigma_icp_q, sigma_icp_d;
  logic [8:0]      sigma_rgbd_q, sigma_rgbd_d;
  logic [PW-1:0]   pose_ident;
  logic [CW-1:0]   n_ext;
  logic [CW-1:0]   d_end;
  logic [CW-1:0]   cyc_inc;

`ifdef VO_SEQ_TIMEOUT_EN
  logic [31:0]     tmo_q, tmo_d;
  logic            err_q, err_d;
`endif

  // Identity pose: unity (Q24) on the diagonal of the 3x4 matrix, zero elsewhere.
  for (genvar gi = 0; gi < 12; gi++) begin : g_ident
    assign pose_ident[gi*P_POSE_BW +: P_POSE_BW] =
      (gi == 0 || gi == 5 || gi == 10) ? P_POSE_BW'(25'd16777216) : '0;
  end

  assign n_ext   = CW'(n_q);
  assign d_end   = LAG_C + n_ext;   // direct phase ends when the lagging stream ends
  assign cyc_inc = cyc_q + CW'(1);

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      n_of_f_q     <= '0;
      n_of_d_q     <= '0;
      n_q          <= '0;
      cyc_q        <= '0;
      iter_q       <= '0;
      frame_sel_q  <= '0;
      f_or_d_q     <= 1'b0;
      pose_q       <= pose_ident;
      sigma_icp_q  <= 84'd7774054188783816;
      sigma_rgbd_q <= 9'd5;
`ifdef VO_SEQ_TIMEOUT_EN
      tmo_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      n_of_f_q     <= n_of_f_d;
      n_of_d_q     <= n_of_d_d;
      n_q          <= n_d;
      cyc_q        <= cyc_d;
      iter_q       <= iter_d;
      frame_sel_q  <= frame_sel_d;
      f_or_d_q     <= f_or_d_d;
      pose_q       <= pose_d;
      sigma_icp_q  <= sigma_icp_d;
      sigma_rgbd_q <= sigma_rgbd_d;
`ifdef VO_SEQ_TIMEOUT_EN
      tmo_q        <= tmo_d;
      err_q        <= err_d;
`endif
    end
  end

  // Next-state logic: sequencing, loads on start and result capture on done.
  always_comb begin
    state_d      = state_q;
    n_of_f_d     = n_of_f_q;
    n_of_d_d     = n_of_d_q;
    n_d          = n_q;
    cyc_d        = cyc_q;
    iter_d       = iter_q;
    frame_sel_d  = frame_sel_q;
    f_or_d_d     = f_or_d_q;
    pose_d       = pose_q;
    sigma_icp_d  = sigma_icp_q;
    sigma_rgbd_d = sigma_rgbd_q;
`ifdef VO_SEQ_TIMEOUT_EN
    tmo_d        = '0;   // watchdog only accumulates while parked in a wait state
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_seq_start && (i_n_of_f != 4'd0)) begin
          n_of_f_d     = i_n_of_f;
          n_of_d_d     = i_n_of_d;
          n_d          = 20'(i_hsize) * 20'(i_vsize);
          pose_d       = i_init_pose;
          sigma_icp_d  = i_sigma_icp;
          sigma_rgbd_d = i_sigma_rgbd;
          frame_sel_d  = '0;
          iter_d       = '0;
          cyc_d        = '0;
          f_or_d_d     = 1'b0;
          state_d      = S_F_STREAM;
        end
      end
      S_F_STREAM: begin
        if (cyc_inc >= n_ext) begin
          cyc_d   = '0;
          state_d = S_F_WAIT;
        end else begin
          cyc_d = cyc_inc;
        end
      end
      S_F_WAIT: begin
        if (i_done) begin
          pose_d   = i_new_pose;
          f_or_d_d = 1'b1;
          cyc_d    = '0;
          iter_d   = '0;
          state_d  = (n_of_d_q == 4'd0) ? S_FINISH : S_D_STREAM;
        end else if (i_feature_ready &&
                     (({1'b0, frame_sel_q} + 5'd1) < {1'b0, n_of_f_q})) begin
          frame_sel_d = frame_sel_q + 4'd1;
          cyc_d       = '0;
          state_d     = S_F_STREAM;
        end else begin
`ifdef VO_SEQ_TIMEOUT_EN
          if (tmo_q >= 32'(P_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
`endif
        end
      end
      S_D_STREAM: begin
        if (cyc_inc >= d_end) begin
          cyc_d   = '0;
          state_d = S_D_WAIT;
        end else begin
          cyc_d = cyc_inc;
        end
      end
      S_D_WAIT: begin
        if (i_done) begin
          pose_d       = i_new_pose;
          sigma_icp_d  = i_sigma_icp_next;
          sigma_rgbd_d = i_sigma_rgbd_next;
          iter_d       = iter_q + 4'd1;
          cyc_d        = '0;
          state_d      = (({1'b0, iter_q} + 5'd1) < {1'b0, n_of_d_q}) ? S_D_STREAM : S_FINISH;
        end else begin
`ifdef VO_SEQ_TIMEOUT_EN
          if (tmo_q >= 32'(P_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
`endif
        end
      end
      S_FINISH: begin
        f_or_d_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stream strobes and indices decoded from the state and stream cycle counter.
  always_comb begin
    o_valid_0     = 1'b0;
    o_valid_1     = 1'b0;
    o_idx_0       = '0;
    o_idx_1       = '0;
    o_frame_start = 1'b0;
    if (state_q == S_F_STREAM) begin
      o_valid_0     = (cyc_q < n_ext);
      o_idx_0       = o_valid_0 ? 19'(cyc_q) : '0;
      o_frame_start = o_valid_0 && (cyc_q == '0);
    end else if (state_q == S_D_STREAM) begin
      o_valid_1     = (cyc_q < n_ext);
      o_idx_1       = o_valid_1 ? 19'(cyc_q) : '0;
      o_valid_0     = (cyc_q >= LAG_C) && (cyc_q < d_end);
      o_idx_0       = o_valid_0 ? 19'(cyc_q - LAG_C) : '0;
      o_frame_start = o_valid_1 && (cyc_q == '0);
    end
  end

  assign o_busy       = (state_q != S_IDLE);
  assign o_seq_done   = (state_q == S_FINISH);
  assign o_f_or_d     = f_or_d_q;
  assign o_frame_sel  = frame_sel_q;
  assign o_pose       = pose_q;
  assign o_sigma_icp  = sigma_icp_q;
  assign o_sigma_rgbd = sigma_rgbd_q;
`ifdef VO_SEQ_TIMEOUT_EN
  assign o_err        = err_q;
`else
  assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_vo_frame_seq.sv
// tb_vo_frame_seq: directed self-checking bench for vo_frame_seq.
// Built with VO_SEQ_TIMEOUT_EN it checks the watchdog; otherwise it checks
// that the wait states hold indefinitely with o_err low.
module tb_vo_frame_seq;

  localparam int BW = 42;
  localparam int PW = 12 * BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          seq_start, feature_ready, done, update_done;
  logic [3:0]    n_of_f, n_of_d;
  logic [9:0]    hsize, vsize;
  logic [PW-1:0] init_pose, new_pose;
  logic [83:0]   sigma_icp_in, sigma_icp_next;
  logic [8:0]    sigma_rgbd_in, sigma_rgbd_next;
  logic          o_frame_start, o_f_or_d, o_valid_0, o_valid_1;
  logic [18:0]   o_idx_0, o_idx_1;
  logic [3:0]    o_frame_sel;
  logic [PW-1:0] o_pose;
  logic [83:0]   o_sigma_icp;
  logic [8:0]    o_sigma_rgbd;
  logic          o_busy, o_seq_done, o_err;

  int total = 0;
  int bad   = 0;

  vo_frame_seq #(.P_REF_LAG(4), .P_POSE_BW(BW), .P_TIMEOUT(100)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_seq_start(seq_start),
    .i_n_of_f(n_of_f), .i_n_of_d(n_of_d), .i_hsize(hsize), .i_vsize(vsize),
    .i_init_pose(init_pose), .i_sigma_icp(sigma_icp_in), .i_sigma_rgbd(sigma_rgbd_in),
    .i_feature_ready(feature_ready), .i_done(done), .i_update_done(update_done),
    .i_new_pose(new_pose), .i_sigma_icp_next(sigma_icp_next), .i_sigma_rgbd_next(sigma_rgbd_next),
    .o_frame_start(o_frame_start), .o_f_or_d(o_f_or_d), .o_valid_0(o_valid_0),
    .o_valid_1(o_valid_1), .o_idx_0(o_idx_0), .o_idx_1(o_idx_1), .o_frame_sel(o_frame_sel),
    .o_pose(o_pose), .o_sigma_icp(o_sigma_icp), .o_sigma_rgbd(o_sigma_rgbd),
    .o_busy(o_busy), .o_seq_done(o_seq_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang want finish");
    $fatal(1, "time limit");
  end

  function automatic logic [PW-1:0] make_pose(input int s);
    logic [PW-1:0] p;
    for (int k = 0; k < 12; k++) p[k*BW +: BW] = 42'(s) * 42'd65536 + 42'(k);
    return p;
  endfunction

  function automatic logic [PW-1:0] ident_pose();
    logic [PW-1:0] p;
    p = '0;
    p[0*BW +: BW]  = 42'd16777216;
    p[5*BW +: BW]  = 42'd16777216;
    p[10*BW +: BW] = 42'd16777216;
    return p;
  endfunction

  function automatic logic [83:0] sig_icp(input int s);
    return 84'(s) * 84'd1000003 + 84'd11;
  endfunction

  function automatic logic [8:0] sig_rgbd(input int s);
    return 9'(s * 7 + 3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks a feature burst on port 0 from stream cycle 'first' to n-1, then its end.
  task automatic f_burst(input logic [3:0] sel, input int first, input int n, input string tag);
    for (int i = first; i < n; i++) begin
      total++;
      if ({o_valid_0, o_valid_1, o_frame_start, o_f_or_d, o_idx_0, o_frame_sel} !==
          {1'b1, 1'b0, (i == 0), 1'b0, 19'(i), sel}) begin
        bad++;
        $display("FAIL %s_burst i=%0d: got v0=%b v1=%b fs=%b fd=%b idx0=%0d sel=%0d want v0=1 v1=0 fs=%b fd=0 idx0=%0d sel=%0d",
                 tag, i, o_valid_0, o_valid_1, o_frame_start, o_f_or_d, o_idx_0, o_frame_sel, (i == 0), i, sel);
      end
      tick();
    end
    total++;
    if ({o_valid_0, o_valid_1, o_busy} !== 3'b001) begin
      bad++;
      $display("FAIL %s_burst_end: got v0=%b v1=%b busy=%b want 0 0 1", tag, o_valid_0, o_valid_1, o_busy);
    end
    $display("txn %s burst sel=%0d cycles=%0d", tag, sel, n - first);
  endtask

  task automatic start_seq(input logic [3:0] nf, input logic [3:0] nd, input logic [9:0] h,
                           input logic [9:0] v, input int seed);
    n_of_f = nf; n_of_d = nd; hsize = h; vsize = v;
    init_pose = make_pose(seed); sigma_icp_in = sig_icp(seed); sigma_rgbd_in = sig_rgbd(seed);
    seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    seq_start = 0; feature_ready = 0; done = 0; update_done = 0;
    n_of_f = 0; n_of_d = 0; hsize = 0; vsize = 0;
    init_pose = '0; new_pose = '0; sigma_icp_in = '0; sigma_icp_next = '0;
    sigma_rgbd_in = '0; sigma_rgbd_next = '0;
    repeat (2) tick();
    total++;
    if ({o_busy, o_valid_0, o_valid_1, o_frame_start, o_seq_done, o_f_or_d, o_err, o_frame_sel, o_idx_0, o_idx_1} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got busy=%b v0=%b v1=%b fs=%b sd=%b fd=%b err=%b sel=%0d idx0=%0d idx1=%0d want all 0",
               o_busy, o_valid_0, o_valid_1, o_frame_start, o_seq_done, o_f_or_d, o_err, o_frame_sel, o_idx_0, o_idx_1);
    end
    total++;
    if (o_pose !== ident_pose()) begin bad++; $display("FAIL reset_pose: got %h want %h", o_pose, ident_pose()); end
    total++;
    if (o_sigma_icp !== 84'd7774054188783816 || o_sigma_rgbd !== 9'd5) begin
      bad++;
      $display("FAIL reset_sigma: got icp=%0d rgbd=%0d want icp=7774054188783816 rgbd=5", o_sigma_icp, o_sigma_rgbd);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_release: got busy=%b want 0", o_busy); end
    $display("txn reset");
  endtask

  task automatic test_feature();
    start_seq(4'd2, 4'd0, 10'd8, 10'd4, 1);
    total++;
    if (o_busy !== 1'b1 || o_pose !== make_pose(1)) begin
      bad++; $display("FAIL feat_load: got busy=%b pose=%h want 1 %h", o_busy, o_pose, make_pose(1));
    end
    f_burst(4'd0, 0, 32, "feat0");
    feature_ready = 1'b1; tick(); feature_ready = 1'b0;
    f_burst(4'd1, 0, 32, "feat1");
    feature_ready = 1'b1; tick(); feature_ready = 1'b0;
    total++;
    if (o_valid_0 !== 1'b0 || o_frame_sel !== 4'd1) begin
      bad++; $display("FAIL feat_extra_ready: got v0=%b sel=%0d want 0 1", o_valid_0, o_frame_sel);
    end
    new_pose = make_pose(2);
    done = 1'b1; tick(); done = 1'b0;
    total++;
    if ({o_seq_done, o_f_or_d} !== 2'b11 || o_pose !== make_pose(2) || o_sigma_icp !== sig_icp(1)) begin
      bad++;
      $display("FAIL feat_done: got sd=%b fd=%b pose=%h icp=%0d want 1 1 %h %0d",
               o_seq_done, o_f_or_d, o_pose, o_sigma_icp, make_pose(2), sig_icp(1));
    end
    tick();
    total++;
    if ({o_seq_done, o_busy, o_f_or_d} !== 3'b000 || o_pose !== make_pose(2)) begin
      bad++; $display("FAIL feat_idle: got sd=%b busy=%b fd=%b pose=%h want 0 0 0 %h",
                      o_seq_done, o_busy, o_f_or_d, o_pose, make_pose(2));
    end
    $display("txn feature sequence");
  endtask

  task automatic test_direct();
    start_seq(4'd1, 4'd3, 10'd8, 10'd4, 3);
    f_burst(4'd0, 0, 32, "dpre");
    new_pose = make_pose(4);
    done = 1'b1; tick(); done = 1'b0;
    total++;
    if (o_pose !== make_pose(4) || o_sigma_icp !== sig_icp(3) || o_sigma_rgbd !== sig_rgbd(3) || o_f_or_d !== 1'b1) begin
      bad++; $display("FAIL dir_enter: got pose=%h icp=%0d rgbd=%0d fd=%b want %h %0d %0d 1",
                      o_pose, o_sigma_icp, o_sigma_rgbd, o_f_or_d, make_pose(4), sig_icp(3), sig_rgbd(3));
    end
    for (int it = 0; it < 3; it++) begin
      for (int c = 0; c < 36; c++) begin
        total++;
        if ({o_valid_1, o_valid_0, o_frame_start, o_f_or_d, o_idx_1, o_idx_0} !==
            {(c < 32), (c >= 4), (c == 0), 1'b1, (c < 32) ? 19'(c) : 19'd0, (c >= 4) ? 19'(c - 4) : 19'd0}) begin
          bad++;
          $display("FAIL dir_stream it=%0d c=%0d: got v1=%b v0=%b fs=%b fd=%b idx1=%0d idx0=%0d want v1=%b v0=%b fs=%b fd=1",
                   it, c, o_valid_1, o_valid_0, o_frame_start, o_f_or_d, o_idx_1, o_idx_0, (c < 32), (c >= 4), (c == 0));
        end
        tick();
      end
      total++;
      if ({o_valid_0, o_valid_1, o_busy, o_seq_done} !== 4'b0010) begin
        bad++; $display("FAIL dir_wait it=%0d: got v0=%b v1=%b busy=%b sd=%b want 0 0 1 0",
                        it, o_valid_0, o_valid_1, o_busy, o_seq_done);
      end
      new_pose = make_pose(10 + it); sigma_icp_next = sig_icp(10 + it); sigma_rgbd_next = sig_rgbd(10 + it);
      done = 1'b1; tick(); done = 1'b0;
      total++;
      if (o_pose !== make_pose(10 + it) || o_sigma_icp !== sig_icp(10 + it) || o_sigma_rgbd !== sig_rgbd(10 + it)) begin
        bad++; $display("FAIL dir_update it=%0d: got icp=%0d rgbd=%0d want %0d %0d",
                        it, o_sigma_icp, o_sigma_rgbd, sig_icp(10 + it), sig_rgbd(10 + it));
      end
      total++;
      if (o_seq_done !== (it == 2)) begin
        bad++; $display("FAIL dir_iter_count it=%0d: got sd=%b want %b", it, o_seq_done, (it == 2));
      end
      $display("txn direct iteration %0d", it);
    end
    tick();
    total++;
    if ({o_busy, o_seq_done, o_f_or_d} !== 3'b000 || o_sigma_rgbd !== sig_rgbd(12)) begin
      bad++; $display("FAIL dir_idle: got busy=%b sd=%b fd=%b rgbd=%0d want 0 0 0 %0d",
                      o_busy, o_seq_done, o_f_or_d, o_sigma_rgbd, sig_rgbd(12));
    end
  endtask

  task automatic test_reset_mid();
    start_seq(4'd1, 4'd2, 10'd2, 10'd2, 5);
    f_burst(4'd0, 0, 4, "rmid");
    new_pose = make_pose(6);
    done = 1'b1; tick(); done = 1'b0;
    tick(); tick();
    total++;
    if (o_valid_1 !== 1'b1 || o_idx_1 !== 19'd2) begin
      bad++; $display("FAIL rmid_pre: got v1=%b idx1=%0d want 1 2", o_valid_1, o_idx_1);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_busy, o_valid_0, o_valid_1, o_frame_start, o_f_or_d} !== 5'b0 || o_pose !== ident_pose() ||
        o_sigma_rgbd !== 9'd5 || o_sigma_icp !== 84'd7774054188783816) begin
      bad++; $display("FAIL rmid_async: got busy=%b v0=%b v1=%b fd=%b rgbd=%0d want 0 0 0 0 5",
                      o_busy, o_valid_0, o_valid_1, o_f_or_d, o_sigma_rgbd);
    end
    tick();
    total++;
    if ({o_busy, o_valid_0, o_valid_1} !== 3'b0 || o_pose !== ident_pose()) begin
      bad++; $display("FAIL rmid_edge: got busy=%b v0=%b v1=%b want 0 0 0", o_busy, o_valid_0, o_valid_1);
    end
    rst_n = 1'b1;
    tick();
    $display("txn reset mid-stream");
  endtask

  task automatic test_ignore();
    start_seq(4'd0, 4'd0, 10'd8, 10'd4, 7);
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL ign_zero_f: got busy=%b want 0", o_busy); end
    tick();
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL ign_zero_f_hold: got busy=%b want 0", o_busy); end
    start_seq(4'd1, 4'd0, 10'd8, 10'd4, 7);
    tick(); tick();
    n_of_f = 4'd3; hsize = 10'd2; vsize = 10'd2; seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
    f_burst(4'd0, 3, 32, "ign");
    feature_ready = 1'b1; tick(); feature_ready = 1'b0;
    total++;
    if ({o_valid_0, o_busy} !== 2'b01 || o_frame_sel !== 4'd0) begin
      bad++; $display("FAIL ign_count: got v0=%b busy=%b sel=%0d want 0 1 0", o_valid_0, o_busy, o_frame_sel);
    end
    done = 1'b1; tick(); done = 1'b0;
    total++;
    if (o_seq_done !== 1'b1) begin bad++; $display("FAIL ign_finish: got sd=%b want 1", o_seq_done); end
    tick();
    $display("txn ignored starts");
  endtask

  task automatic test_priority();
    start_seq(4'd2, 4'd0, 10'd2, 10'd2, 8);
    new_pose = make_pose(9);
    done = 1'b1; feature_ready = 1'b1; tick(); done = 1'b0; feature_ready = 1'b0;
    total++;
    if (o_pose !== make_pose(8) || o_f_or_d !== 1'b0 || o_frame_sel !== 4'd0) begin
      bad++; $display("FAIL pri_stream_ignore: got pose=%h fd=%b sel=%0d want %h 0 0",
                      o_pose, o_f_or_d, o_frame_sel, make_pose(8));
    end
    f_burst(4'd0, 1, 4, "pri");
    done = 1'b1; feature_ready = 1'b1; tick(); done = 1'b0; feature_ready = 1'b0;
    total++;
    if ({o_seq_done, o_f_or_d, o_valid_0} !== 3'b110 || o_frame_sel !== 4'd0 || o_pose !== make_pose(9)) begin
      bad++; $display("FAIL pri_done_wins: got sd=%b fd=%b v0=%b sel=%0d want 1 1 0 0",
                      o_seq_done, o_f_or_d, o_valid_0, o_frame_sel);
    end
    tick();
    $display("txn done/feature_ready priority");
  endtask

  task automatic test_timeout();
    start_seq(4'd1, 4'd0, 10'd2, 10'd2, 11);
    f_burst(4'd0, 0, 4, "tmo");
`ifdef VO_SEQ_TIMEOUT_EN
    begin
      int k;
      k = 0;
      while (o_seq_done !== 1'b1 && k < 300) begin
        tick();
        k++;
      end
      total++;
      if (k != 100) begin bad++; $display("FAIL tmo_cycles: got %0d want 100", k); end
      total++;
      if (o_err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", o_err); end
      tick();
      total++;
      if ({o_busy, o_err} !== 2'b01) begin
        bad++; $display("FAIL tmo_sticky: got busy=%b err=%b want 0 1", o_busy, o_err);
      end
    end
`else
    repeat (150) tick();
    total++;
    if ({o_busy, o_seq_done, o_err} !== 3'b100) begin
      bad++; $display("FAIL tmo_hold: got busy=%b sd=%b err=%b want 1 0 0", o_busy, o_seq_done, o_err);
    end
    done = 1'b1; tick(); done = 1'b0;
    total++;
    if ({o_seq_done, o_err} !== 2'b10) begin
      bad++; $display("FAIL tmo_exit: got sd=%b err=%b want 1 0", o_seq_done, o_err);
    end
    tick();
`endif
    $display("txn wait-state watchdog");
  endtask

  initial begin
    test_reset();
    test_feature();
    test_direct();
    test_reset_mid();
    test_ignore();
    test_priority();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
